capture_stream_engine: RTL and testbench
========================================

CAPTURE_STREAM_ENGINE -- requirements
Module: capture_stream_engine

Interface
REQ-001 SHALL have parameter NCH, default 14, meaning the number of ADC channels per FIFO row; it SHALL be even and in the range 2..16.
REQ-002 SHALL have parameter SW, default 10, meaning the sample width in bits; it SHALL be in the range 1..16.
REQ-003 SHALL have parameter VERSION, default 32'd5, meaning the firmware version returned by opcode 0x02.
REQ-004 clk  in  1  single clock for all logic; rising-edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 i_tvalid / i_tready / i_tdata  in / out / 8  AXI-stream command byte slave.
REQ-007 o_tvalid / o_tready  out / in  1  AXI-stream response master handshake.
REQ-008 o_tdata / o_tkeep / o_tlast  out  32 / 4 / 1  response data, byte keep, last-word flag.
REQ-009 fifo_rd / fifo_empty  out / in  1  sample FIFO read strobe; FIFO empty flag.
REQ-010 fifo_data  in  NCH*SW  sample row, valid exactly 1 cycle after fifo_rd; channel c occupies bits [c*SW +: SW].
REQ-011 fifo_used  in  12  FIFO fill level.
REQ-012 cap_len / arm  out  16 / 1  capture length; one-cycle arm pulse.
REQ-013 err_cnt  out  8  count of unknown opcodes, saturating.

Function
REQ-014 Command = 8 bytes b0..b7, received in order; i_tready SHALL be 1 only in state RX; a byte SHALL transfer when i_tvalid&&i_tready.
REQ-015 States: RX, DECODE, RESP, S_FETCH, S_WAIT, S_SEND. RX->DECODE on the 8th byte; DECODE SHALL take exactly 1 cycle.
REQ-016 Opcode 0x02: RESP with o_tdata=VERSION.
REQ-017 Opcode 0x04: RESP with o_tdata={20'd0,fifo_used}, sampled in DECODE.
REQ-018 Opcode 0x05: cap_len<={b5,b4}, arm=1 for 1 cycle, RESP with o_tdata={16'd0,b5,b4}.
REQ-019 Opcode 0x08: chmask<={b3,b2}, applied to channels 0..NCH-1; RESP echoes {16'd0,b3,b2}.
REQ-020 Opcode 0x00: stream N={b5,b4} words; for N==0, return to RX with no output.
REQ-021 Any other opcode: no output; err_cnt+1, saturating at 255; return to RX.
REQ-022 RESP: one word, o_tkeep=4'b1111, o_tlast=1; o_tvalid SHALL be asserted the cycle after DECODE.
REQ-023 All master words: o_tvalid SHALL be held and o_tdata/o_tlast SHALL be stable until o_tready; the word retires on o_tvalid&&o_tready.
REQ-024 Stream row: S_FETCH asserts fifo_rd for one cycle when fifo_empty==0, and waits otherwise; S_WAIT latches fifo_data into a row register; S_SEND emits the row words.
REQ-025 Row words: for pair k=0..NCH/2-1, when chmask[2k] or chmask[2k+1] is set, emit {(16-SW)'0,ch(2k+1),(16-SW)'0,ch(2k)}, ascending k; then emit marker 32'hDEADBEEF.
REQ-026 A disabled channel within an enabled pair SHALL be sent as zero; chmask==0 SHALL yield marker-only rows.
REQ-027 Word counter: 16-bit, counting down from N; o_tlast=1 only on word N; after word N is accepted, return to RX.
REQ-028 Partial rows: when word N falls mid-row, the rest of that row SHALL be discarded; the next stream command SHALL start with a fresh FIFO read.
REQ-029 Next row fetch: after a marker is accepted with words remaining, go to S_FETCH.
REQ-030 fifo_rd SHALL never assert when fifo_empty==1 or outside S_FETCH.
REQ-031 chmask SHALL be sampled at stream start and held for the entire stream command.
REQ-032 o_tkeep SHALL be 4'b1111 on all words.

Reset
REQ-033 On rst: state=RX, i_tready=1, o_tvalid=0, o_tdata=0, o_tlast=0, o_tkeep=0, fifo_rd=0, arm=0, cap_len=0, chmask=all ones, err_cnt=0, byte and word counters=0.
REQ-034 rst mid-command or mid-stream SHALL abandon the partial command or stream, drop any pending word, and take effect on the next clk edge.

Verification
REQ-035 Opcode 02, then 6 pad bytes -> exactly one word 32'h00000005 with o_tlast=1; i_tready=0 from DECODE until that word is accepted.
REQ-036 NCH=14, SW=10, chmask=16'h3FFF, stream N=16, FIFO holding 2 rows -> 7 data words + DEADBEEF, twice; o_tlast on word 16; fifo_rd pulsed exactly twice.
REQ-037 chmask=16'h0003, stream N=5 -> words: pair0, DEADBEEF, pair0, DEADBEEF, pair0; o_tlast on word 5; the third row is discarded.
REQ-038 o_tready toggled randomly during a stream -> no word lost or duplicated; o_tdata stable while o_tvalid&&!o_tready.
REQ-039 Opcode 0x7F sent 300 times -> err_cnt=255, no output; then opcode 0x05 with b5b4=16'h0400 -> arm pulse of 1 cycle, cap_len=0x0400, echo 32'h00000400.
REQ-040 rst pulse during S_SEND with fifo_empty=1 after reset -> o_tvalid=0 next cycle, state RX, fifo_rd stays 0.

Source files
------------

// File: rtl/capture_stream_engine.sv
// Command-driven capture controller: decodes 8-byte commands from an AXI-stream
// slave and answers with single status words or masked ADC sample rows.
module capture_stream_engine #(
    parameter int          NCH     = 14,
    parameter int          SW      = 10,
    parameter logic [31:0] VERSION = 32'd5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_tvalid,
    output logic              i_tready,
    input  logic [7:0]        i_tdata,
    output logic              o_tvalid,
    input  logic              o_tready,
    output logic [31:0]       o_tdata,
    output logic [3:0]        o_tkeep,
    output logic              o_tlast,
    output logic              fifo_rd,
    input  logic              fifo_empty,
    input  logic [NCH*SW-1:0] fifo_data,
    input  logic [11:0]       fifo_used,
    output logic [15:0]       cap_len,
    output logic              arm,
    output logic [7:0]        err_cnt
);
    localparam int          NP     = NCH / 2;
    localparam logic [31:0] MARKER = 32'hDEADBEEF;

    typedef enum logic [2:0] {RX, DECODE, RESP, S_FETCH, S_WAIT, S_SEND} state_t;

    state_t            state;
    logic [2:0]        byte_cnt;
    logic [7:0]        op, b2, b3, b4, b5;
    logic [15:0]       arg_lo, arg_hi;
    logic [15:0]       word_cnt;
    logic [NCH-1:0]    chmask, smask;
    logic [NCH*SW-1:0] row;
    logic [3:0]        pair;

    assign arg_lo  = {b3, b2};
    assign arg_hi  = {b5, b4};
    // Read strobe must be gated by the live empty flag, so it cannot be registered.
    assign fifo_rd = (state == S_FETCH) && !fifo_empty;

    // First pair at or after 'from' with either channel enabled; NP selects the marker.
    function automatic logic [3:0] next_pair(input logic [NCH-1:0] m, input logic [3:0] from);
        logic [3:0] r;
        logic       found;
        r     = 4'(NP);
        found = 1'b0;
        for (int unsigned k = 0; k < NP; k++) begin
            if (!found && k >= 32'(from) && (m[2*k] || m[2*k+1])) begin
                r     = 4'(k);
                found = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] row_word(input logic [NCH*SW-1:0] r, input logic [NCH-1:0] m,
                                             input logic [3:0] k);
        logic [31:0]  w;
        int unsigned  ki;
        w  = '0;
        ki = 32'(k);
        if (ki >= NP) begin
            w = MARKER;
        end else begin
            if (m[2*ki])   w[SW-1:0]  = r[(2*ki)*SW +: SW];
            if (m[2*ki+1]) w[16 +: SW] = r[(2*ki+1)*SW +: SW];
        end
        return w;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RX;
            i_tready <= 1'b1;
            o_tvalid <= 1'b0;
            o_tdata  <= '0;
            o_tlast  <= 1'b0;
            o_tkeep  <= '0;
            arm      <= 1'b0;
            cap_len  <= '0;
            chmask   <= '1;
            smask    <= '1;
            err_cnt  <= '0;
            byte_cnt <= '0;
            word_cnt <= '0;
            op       <= '0;
            b2       <= '0;
            b3       <= '0;
            b4       <= '0;
            b5       <= '0;
            row      <= '0;
            pair     <= '0;
        end else begin
            arm <= 1'b0;
            case (state)
                RX: begin
                    if (i_tvalid && i_tready) begin
                        case (byte_cnt)
                            3'd0:    op <= i_tdata;
                            3'd2:    b2 <= i_tdata;
                            3'd3:    b3 <= i_tdata;
                            3'd4:    b4 <= i_tdata;
                            3'd5:    b5 <= i_tdata;
                            default: ;
                        endcase
                        byte_cnt <= byte_cnt + 3'd1;
                        if (byte_cnt == 3'd7) begin
                            state    <= DECODE;
                            i_tready <= 1'b0;
                        end
                    end
                end
                DECODE: begin
                    case (op)
                        8'h02, 8'h04, 8'h05, 8'h08: begin
                            o_tvalid <= 1'b1;
                            o_tlast  <= 1'b1;
                            o_tkeep  <= 4'hF;
                            state    <= RESP;
                            case (op)
                                8'h02:   o_tdata <= VERSION;
                                8'h04:   o_tdata <= {20'd0, fifo_used};
                                8'h05: begin
                                    o_tdata <= {16'd0, arg_hi};
                                    cap_len <= arg_hi;
                                    arm     <= 1'b1;
                                end
                                default: begin
                                    o_tdata <= {16'd0, arg_lo};
                                    chmask  <= arg_lo[NCH-1:0];
                                end
                            endcase
                        end
                        8'h00: begin
                            word_cnt <= arg_hi;
                            smask    <= chmask;
                            if (arg_hi == 16'd0) begin
                                state    <= RX;
                                i_tready <= 1'b1;
                            end else begin
                                state <= S_FETCH;
                            end
                        end
                        default: begin
                            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
                            state    <= RX;
                            i_tready <= 1'b1;
                        end
                    endcase
                end
                RESP: begin
                    if (o_tready) begin
                        o_tvalid <= 1'b0;
                        o_tlast  <= 1'b0;
                        state    <= RX;
                        i_tready <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (!fifo_empty) state <= S_WAIT;
                end
                S_WAIT: begin
                    // Row data is valid now; build the first word straight from the FIFO bus.
                    row      <= fifo_data;
                    pair     <= next_pair(smask, 4'd0);
                    o_tdata  <= row_word(fifo_data, smask, next_pair(smask, 4'd0));
                    o_tlast  <= (word_cnt == 16'd1);
                    o_tkeep  <= 4'hF;
                    o_tvalid <= 1'b1;
                    state    <= S_SEND;
                end
                S_SEND: begin
                    if (o_tready) begin
                        word_cnt <= word_cnt - 16'd1;
                        if (word_cnt == 16'd1) begin
                            o_tvalid <= 1'b0;
                            o_tlast  <= 1'b0;
                            state    <= RX;
                            i_tready <= 1'b1;
                        end else if (32'(pair) >= NP) begin
                            o_tvalid <= 1'b0;
                            state    <= S_FETCH;
                        end else begin
                            pair    <= next_pair(smask, pair + 4'd1);
                            o_tdata <= row_word(row, smask, next_pair(smask, pair + 4'd1));
                            o_tlast <= (word_cnt == 16'd2);
                        end
                    end
                end
                default: begin
                    state    <= RX;
                    i_tready <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_capture_stream_engine.sv
// Randomized bench for capture_stream_engine with a queue-based reference model
// of command responses, FIFO row consumption and channel masking.
module tb_capture_stream_engine;
    localparam int          NCH = 14;
    localparam int          SW  = 10;
    localparam int          NP  = NCH / 2;
    localparam logic [31:0] VER = 32'd5;

    logic              clk, rst;
    logic              i_tvalid, i_tready;
    logic [7:0]        i_tdata;
    logic              o_tvalid, o_tready, o_tlast;
    logic [31:0]       o_tdata;
    logic [3:0]        o_tkeep;
    logic              fifo_rd, fifo_empty;
    logic [NCH*SW-1:0] fifo_data;
    logic [11:0]       fifo_used;
    logic [15:0]       cap_len;
    logic              arm;
    logic [7:0]        err_cnt;

    capture_stream_engine #(.NCH(NCH), .SW(SW), .VERSION(VER)) dut (
        .clk(clk), .rst(rst),
        .i_tvalid(i_tvalid), .i_tready(i_tready), .i_tdata(i_tdata),
        .o_tvalid(o_tvalid), .o_tready(o_tready), .o_tdata(o_tdata),
        .o_tkeep(o_tkeep), .o_tlast(o_tlast),
        .fifo_rd(fifo_rd), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
        .fifo_used(fifo_used), .cap_len(cap_len), .arm(arm), .err_cnt(err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int rd_cnt = 0, rd_empty_err = 0, stab_err = 0, keep_err = 0, arm_cnt = 0;
    int ready_mode = 0;
    logic rd_pending = 1'b0, prev_pend = 1'b0, prev_last = 1'b0;
    logic [31:0] prev_data = '0;

    logic [NCH*SW-1:0] fifo_q[$];
    logic [NCH*SW-1:0] ref_q[$];
    logic [32:0]       obs[$];
    logic [32:0]       exp_q[$];
    logic [15:0]       model_mask = 16'hFFFF;
    logic [15:0]       model_cap  = '0;
    int                model_err  = 0;

    task automatic check_eq(input string tag, input logic [32:0] got, input logic [32:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Environment: FIFO with one-cycle read latency, random o_tready, output monitor.
    always @(negedge clk) begin
        if (rd_pending) begin
            if (fifo_q.size() > 0) fifo_data = fifo_q.pop_front();
            fifo_empty = (fifo_q.size() == 0);
            rd_pending = 1'b0;
        end
        if (fifo_rd) begin
            rd_cnt++;
            if (fifo_empty) rd_empty_err++;
            rd_pending = 1'b1;
        end
        if (arm) arm_cnt++;
        case (ready_mode)
            0:       o_tready = 1'b1;
            1:       o_tready = 1'($urandom_range(0, 1));
            default: o_tready = 1'b0;
        endcase
        if (rst) begin
            prev_pend = 1'b0;
        end else begin
            if (prev_pend && !(o_tvalid && o_tdata == prev_data && o_tlast == prev_last)) stab_err++;
            if (o_tvalid && o_tready) begin
                obs.push_back({o_tlast, o_tdata});
                if (o_tkeep !== 4'hF) keep_err++;
            end
            prev_pend = o_tvalid && !o_tready;
            prev_data = o_tdata;
            prev_last = o_tlast;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        i_tvalid = 1'b1;
        i_tdata  = b;
        n = 0;
        while (!i_tready && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        if (!i_tready) check_eq("tready_wait", 33'(i_tready), 33'd1);
        @(posedge clk); #1;
        i_tvalid = 1'b0;
    endtask

    task automatic send_cmd(input logic [7:0] op, input logic [15:0] lo, input logic [15:0] hi);
        send_byte(op);
        send_byte(8'($urandom));
        send_byte(lo[7:0]);
        send_byte(lo[15:8]);
        send_byte(hi[7:0]);
        send_byte(hi[15:8]);
        send_byte(8'($urandom));
        send_byte(8'($urandom));
    endtask

    function automatic int words_per_row(input logic [15:0] m);
        int w = 1;
        for (int k = 0; k < NP; k++) if (m[2*k] || m[2*k+1]) w++;
        return w;
    endfunction

    task automatic load_rows(input int k);
        logic [NCH*SW-1:0] r;
        for (int i = 0; i < k; i++) begin
            for (int c = 0; c < NCH; c++) r[c*SW +: SW] = SW'($urandom);
            fifo_q.push_back(r);
            ref_q.push_back(r);
        end
        fifo_empty = (fifo_q.size() == 0);
    endtask

    task automatic ensure_rows(input int n);
        int wpr  = words_per_row(model_mask);
        int need = (n + wpr - 1) / wpr;
        if (need > ref_q.size()) load_rows(need - ref_q.size());
    endtask

    task automatic run_cmd(input string name, input logic [7:0] op, input logic [15:0] lo,
                           input logic [15:0] hi);
        int rows = 0, rd0, arm0, n, lim;
        logic [NCH*SW-1:0] r;
        logic [15:0] hw, lw;
        exp_q.delete();
        case (op)
            8'h02: exp_q.push_back({1'b1, VER});
            8'h04: exp_q.push_back({1'b1, 20'd0, fifo_used});
            8'h05: begin exp_q.push_back({1'b1, 16'd0, hi}); model_cap = hi; end
            8'h08: begin exp_q.push_back({1'b1, 16'd0, lo}); model_mask = lo; end
            8'h00: begin
                while (exp_q.size() < int'(hi)) begin
                    r = ref_q.pop_front();
                    rows++;
                    for (int k = 0; k < NP; k++) begin
                        if ((model_mask[2*k] || model_mask[2*k+1]) && exp_q.size() < int'(hi)) begin
                            lw = model_mask[2*k]   ? 16'(r[(2*k)*SW +: SW])   : 16'd0;
                            hw = model_mask[2*k+1] ? 16'(r[(2*k+1)*SW +: SW]) : 16'd0;
                            exp_q.push_back({1'b0, hw, lw});
                        end
                    end
                    if (exp_q.size() < int'(hi)) exp_q.push_back({1'b0, 32'hDEADBEEF});
                end
                if (exp_q.size() > 0) exp_q[exp_q.size()-1][32] = 1'b1;
            end
            default: if (model_err < 255) model_err++;
        endcase
        obs.delete();
        rd0  = rd_cnt;
        arm0 = arm_cnt;
        send_cmd(op, lo, hi);
        n = 0;
        while (obs.size() < exp_q.size() && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (4) @(posedge clk);
        #1;
        check_eq({name, "_nwords"}, 33'(obs.size()), 33'(exp_q.size()));
        lim = (obs.size() < exp_q.size()) ? obs.size() : exp_q.size();
        for (int i = 0; i < lim; i++) check_eq($sformatf("%s_w%0d", name, i), obs[i], exp_q[i]);
        check_eq({name, "_fifo_rd"}, 33'(rd_cnt - rd0), 33'(rows));
        check_eq({name, "_idle"}, 33'(i_tready), 33'd1);
        check_eq({name, "_err_cnt"}, 33'(err_cnt), 33'(model_err));
        if (op == 8'h05) begin
            check_eq({name, "_arm"}, 33'(arm_cnt - arm0), 33'd1);
            check_eq({name, "_cap_len"}, 33'(cap_len), 33'(model_cap));
        end
    endtask

    initial begin
        int n;
        logic [15:0] m;
        rst = 1'b1; i_tvalid = 1'b0; i_tdata = '0; fifo_used = '0;
        fifo_data = '0; fifo_empty = 1'b1; o_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_i_tready", 33'(i_tready), 33'd1);
        check_eq("rst_o_tvalid", 33'(o_tvalid), 33'd0);
        check_eq("rst_o_tdata", 33'(o_tdata), 33'd0);
        check_eq("rst_o_tlast", 33'(o_tlast), 33'd0);
        check_eq("rst_o_tkeep", 33'(o_tkeep), 33'd0);
        check_eq("rst_fifo_rd", 33'(fifo_rd), 33'd0);
        check_eq("rst_arm", 33'(arm), 33'd0);
        check_eq("rst_cap_len", 33'(cap_len), 33'd0);
        check_eq("rst_err_cnt", 33'(err_cnt), 33'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Version word held while the sink stalls; command port stays closed.
        obs.delete();
        ready_mode = 2;
        send_cmd(8'h02, 16'h0, 16'h0);
        repeat (3) @(posedge clk);
        #1;
        check_eq("hold_valid", 33'(o_tvalid), 33'd1);
        check_eq("hold_tready", 33'(i_tready), 33'd0);
        check_eq("hold_data", {o_tlast, o_tdata}, {1'b1, VER});
        ready_mode = 0;
        repeat (4) @(posedge clk);
        #1;
        check_eq("hold_nwords", 33'(obs.size()), 33'd1);
        if (obs.size() > 0) check_eq("hold_word", obs[0], {1'b1, VER});

        fifo_used = 12'($urandom);
        run_cmd("used", 8'h04, 16'h0, 16'h0);

        ensure_rows(16);
        run_cmd("full16", 8'h00, 16'h0, 16'd16);

        run_cmd("mask3", 8'h08, 16'h0003, 16'h0);
        ensure_rows(5);
        run_cmd("part5", 8'h00, 16'h0, 16'd5);

        run_cmd("n0", 8'h00, 16'h0, 16'd0);

        for (int it = 0; it < 8; it++) begin
            m = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
            run_cmd($sformatf("rmask%0d", it), 8'h08, m, 16'h0);
            n = $urandom_range(1, 40);
            ensure_rows(n);
            ready_mode = $urandom_range(0, 1);
            run_cmd($sformatf("rstream%0d", it), 8'h00, 16'h0, 16'(n));
            ready_mode = 0;
        end

        obs.delete();
        for (int i = 0; i < 300; i++) send_cmd(8'h7F, 16'($urandom), 16'($urandom));
        model_err = 255;
        repeat (4) @(posedge clk);
        #1;
        check_eq("bad_op_nwords", 33'(obs.size()), 33'd0);
        check_eq("bad_op_err_cnt", 33'(err_cnt), 33'd255);
        run_cmd("arm", 8'h05, 16'h0, 16'h0400);

        // Reset while a stream word is stalled in the output register.
        fifo_q.delete(); ref_q.delete(); fifo_empty = 1'b1;
        run_cmd("maskall", 8'h08, 16'hFFFF, 16'h0);
        ready_mode = 2;
        load_rows(1);
        ref_q.delete();
        send_cmd(8'h00, 16'h0, 16'd10);
        n = 0;
        while (!o_tvalid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("send_valid", 33'(o_tvalid), 33'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_eq("rst_send_valid", 33'(o_tvalid), 33'd0);
        check_eq("rst_send_tready", 33'(i_tready), 33'd1);
        check_eq("rst_send_rd", 33'(fifo_rd), 33'd0);
        n = rd_cnt;
        repeat (10) @(posedge clk);
        #1;
        check_eq("rst_no_rd", 33'(rd_cnt - n), 33'd0);
        check_eq("rst_idle_valid", 33'(o_tvalid), 33'd0);
        check_eq("rst_err_clr", 33'(err_cnt), 33'd0);
        check_eq("rst_cap_clr", 33'(cap_len), 33'd0);
        model_mask = 16'hFFFF; model_err = 0; model_cap = '0;
        ready_mode = 0;
        run_cmd("ver_after_rst", 8'h02, 16'h0, 16'h0);

        check_eq("stability", 33'(stab_err), 33'd0);
        check_eq("tkeep", 33'(keep_err), 33'd0);
        check_eq("rd_when_empty", 33'(rd_empty_err), 33'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
